// File: rtl/agu_exec_stage.sv
// agu_exec_stage
//   Address-generation execution stage sitting behind the AGU issue queue.
//   One register stage (S1) captures the issued instruction; the effective
//   address op1 + imm and its alignment class are computed from S1 and
//   pushed into a small FIFO that feeds the load/store queue.
//
// Ports
//   clk, rst (async, active-low), flush (sync squash of all in-flight work)
//   iq_*  : issue-side valid/ready handshake and instruction fields
//   lsq_* : FIFO head presented to the LSQ with valid/ready handshake
module agu_exec_stage #(
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 6,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              iq_valid,
    output logic              iq_ready,
    input  logic [DATA_W-1:0] iq_op1_data,
    input  logic [DATA_W-1:0] iq_op2_data,
    input  logic [DATA_W-1:0] iq_imm,
    input  logic [TAG_W-1:0]  iq_rd_tag,
    input  logic              iq_rd_tag_valid,
    input  logic [2:0]        iq_funct3,
    input  logic              iq_ls,
    output logic              lsq_valid,
    input  logic              lsq_ready,
    output logic [DATA_W-1:0] lsq_addr,
    output logic [DATA_W-1:0] lsq_store_data,
    output logic [TAG_W-1:0]  lsq_rd_tag,
    output logic              lsq_rd_tag_valid,
    output logic [2:0]        lsq_funct3,
    output logic              lsq_ls,
    output logic              lsq_misaligned
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2*DATA_W + TAG_W + 6;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_DEPTH);

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_op1_q;
    logic [DATA_W-1:0] s1_op2_q;
    logic [DATA_W-1:0] s1_imm_q;
    logic [TAG_W-1:0]  s1_tag_q;
    logic              s1_tag_valid_q;
    logic [2:0]        s1_funct3_q;
    logic              s1_ls_q;

    logic [ENT_W-1:0]  fifo_q [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              s1_adv;
    logic              accept;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] eff_addr;
    logic              misaligned;
    logic [ENT_W-1:0]  s1_entry;

    // iq_ready depends only on registered state and flush, so LSQ
    // backpressure never ripples combinationally into the issue queue.
    assign s1_adv   = s1_valid_q & (count_q != FULL_CNT);
    assign iq_ready = ~flush & (~s1_valid_q | s1_adv);
    assign accept   = iq_valid & iq_ready;
    assign push     = s1_adv & ~flush;
    assign lsq_valid = (count_q != '0);
    assign pop      = lsq_valid & lsq_ready;
    assign eff_addr = s1_op1_q + s1_imm_q;

    always_comb begin
        misaligned = 1'b0;
        case (s1_funct3_q[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = eff_addr[0];
            2'b10:   misaligned = |eff_addr[1:0];
            default: misaligned = 1'b1;
        endcase
        // Unsigned-width codes have no meaning for stores.
        if (s1_ls_q && s1_funct3_q[2]) misaligned = 1'b1;
    end

    assign s1_entry = {eff_addr, s1_op2_q, s1_tag_q, s1_tag_valid_q,
                       s1_funct3_q, s1_ls_q, misaligned};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q     <= 1'b0;
            s1_op1_q       <= '0;
            s1_op2_q       <= '0;
            s1_imm_q       <= '0;
            s1_tag_q       <= '0;
            s1_tag_valid_q <= 1'b0;
            s1_funct3_q    <= '0;
            s1_ls_q        <= 1'b0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (accept) begin
            s1_valid_q     <= 1'b1;
            s1_op1_q       <= iq_op1_data;
            s1_op2_q       <= iq_op2_data;
            s1_imm_q       <= iq_imm;
            s1_tag_q       <= iq_rd_tag;
            s1_tag_valid_q <= iq_rd_tag_valid;
            s1_funct3_q    <= iq_funct3;
            s1_ls_q        <= iq_ls;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Pointers are PTR_W bits wide and OUT_DEPTH is a power of two, so the
    // natural overflow of the increment is the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= s1_entry;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign {lsq_addr, lsq_store_data, lsq_rd_tag, lsq_rd_tag_valid,
            lsq_funct3, lsq_ls, lsq_misaligned} = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_agu_exec_stage.sv
module tb_agu_exec_stage;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int ENT_W  = 2*DATA_W + TAG_W + 6;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              iq_valid;
    logic              iq_ready;
    logic [DATA_W-1:0] iq_op1_data;
    logic [DATA_W-1:0] iq_op2_data;
    logic [DATA_W-1:0] iq_imm;
    logic [TAG_W-1:0]  iq_rd_tag;
    logic              iq_rd_tag_valid;
    logic [2:0]        iq_funct3;
    logic              iq_ls;
    logic              lsq_valid;
    logic              lsq_ready;
    logic [DATA_W-1:0] lsq_addr;
    logic [DATA_W-1:0] lsq_store_data;
    logic [TAG_W-1:0]  lsq_rd_tag;
    logic              lsq_rd_tag_valid;
    logic [2:0]        lsq_funct3;
    logic              lsq_ls;
    logic              lsq_misaligned;

    agu_exec_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W), .OUT_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iq_valid(iq_valid), .iq_ready(iq_ready),
        .iq_op1_data(iq_op1_data), .iq_op2_data(iq_op2_data), .iq_imm(iq_imm),
        .iq_rd_tag(iq_rd_tag), .iq_rd_tag_valid(iq_rd_tag_valid),
        .iq_funct3(iq_funct3), .iq_ls(iq_ls),
        .lsq_valid(lsq_valid), .lsq_ready(lsq_ready), .lsq_addr(lsq_addr),
        .lsq_store_data(lsq_store_data), .lsq_rd_tag(lsq_rd_tag),
        .lsq_rd_tag_valid(lsq_rd_tag_valid), .lsq_funct3(lsq_funct3),
        .lsq_ls(lsq_ls), .lsq_misaligned(lsq_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_pops   = 0;
    logic last_acc;
    logic [ENT_W-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: what the LSQ must see for one accepted instruction.
    function automatic logic [ENT_W-1:0] model(
        input logic [DATA_W-1:0] op1, input logic [DATA_W-1:0] op2,
        input logic [DATA_W-1:0] imm, input logic [TAG_W-1:0] tag,
        input logic tv, input logic [2:0] f3, input logic ls);
        logic [DATA_W-1:0] addr;
        int unsigned size;
        logic mis;
        addr = op1 + imm;
        size = 1 << f3[1:0];
        mis  = (f3[1:0] == 2'b11) || (ls && f3[2]) || ((addr % size) != 0);
        return {addr, op2, tag, tv, f3, ls, mis};
    endfunction

    // One clock: observe handshakes mid-cycle, score pops, update the model.
    task automatic step();
        logic acc, pop;
        logic [ENT_W-1:0] acc_ent;
        @(negedge clk);
        acc = iq_valid && iq_ready;
        pop = lsq_valid && lsq_ready;
        acc_ent = model(iq_op1_data, iq_op2_data, iq_imm, iq_rd_tag,
                        iq_rd_tag_valid, iq_funct3, iq_ls);
        if (flush) chk("ready_in_flush", iq_ready, 0);
        if (pop) begin
            n_pops++;
            chk("pop_has_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                chk("sb_entry", {lsq_addr, lsq_store_data, lsq_rd_tag, lsq_rd_tag_valid,
                                 lsq_funct3, lsq_ls, lsq_misaligned}, exp_q.pop_front());
        end
        @(posedge clk);
        if (flush) exp_q.delete();
        if (acc) exp_q.push_back(acc_ent);
        last_acc = acc;
        #1;
    endtask

    task automatic issue(input logic [31:0] op1, input logic [31:0] op2,
                         input logic [31:0] imm, input logic [5:0] tag,
                         input logic [2:0] f3, input logic ls);
        iq_valid = 1'b1; iq_op1_data = op1; iq_op2_data = op2; iq_imm = imm;
        iq_rd_tag = tag; iq_rd_tag_valid = 1'b1; iq_funct3 = f3; iq_ls = ls;
    endtask

    task automatic idle();
        iq_valid = 1'b0;
    endtask

    // Single instruction through an empty pipe with the LSQ always ready.
    task automatic single(input string nm, input logic [31:0] op1, input logic [31:0] op2,
                          input logic [31:0] imm, input logic [5:0] tag, input logic [2:0] f3,
                          input logic ls, input logic [31:0] exp_addr, input logic exp_mis);
        lsq_ready = 1'b1;
        issue(op1, op2, imm, tag, f3, ls);
        step();
        chk({nm, "_acc"}, last_acc, 1);
        idle();
        chk({nm, "_lat1"}, lsq_valid, 0);
        step();
        chk({nm, "_lat2"}, lsq_valid, 1);
        chk({nm, "_addr"}, lsq_addr, exp_addr);
        chk({nm, "_mis"}, lsq_misaligned, exp_mis);
        chk({nm, "_tag"}, lsq_rd_tag, tag);
        chk({nm, "_data"}, lsq_store_data, op2);
        step();
        chk({nm, "_empty"}, lsq_valid, 0);
    endtask

    initial begin
        int guard;
        int pops0;
        rst = 1'b0; flush = 1'b0; lsq_ready = 1'b0; iq_valid = 1'b0;
        iq_op1_data = '0; iq_op2_data = '0; iq_imm = '0; iq_rd_tag = '0;
        iq_rd_tag_valid = 1'b0; iq_funct3 = '0; iq_ls = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", lsq_valid, 0);
        chk("rst_addr", lsq_addr, 0);
        chk("rst_tagv", lsq_rd_tag_valid, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", iq_ready, 1);

        single("lw", 32'h1000, 32'h0, 32'h10, 6'd5, 3'b010, 1'b0, 32'h1010, 1'b0);
        single("sw_neg", 32'h2000, 32'hDEADBEEF, 32'hFFFFFFFC, 6'd7, 3'b010, 1'b1, 32'h1FFC, 1'b0);
        single("wrap", 32'hFFFFFFFF, 32'h0, 32'h1, 6'd9, 3'b000, 1'b0, 32'h0, 1'b0);
        single("lh_odd", 32'h1001, 32'h0, 32'h0, 6'd1, 3'b001, 1'b0, 32'h1001, 1'b1);
        single("lw_half", 32'h1002, 32'h0, 32'h0, 6'd2, 3'b010, 1'b0, 32'h1002, 1'b1);
        single("lb", 32'h1003, 32'h0, 32'h0, 6'd3, 3'b000, 1'b0, 32'h1003, 1'b0);
        single("f3_011", 32'h1000, 32'h0, 32'h0, 6'd4, 3'b011, 1'b0, 32'h1000, 1'b1);
        single("st_f3_100", 32'h1000, 32'h55, 32'h0, 6'd6, 3'b100, 1'b1, 32'h1000, 1'b1);
        single("lhu_even", 32'h1000, 32'h0, 32'h2, 6'd8, 3'b101, 1'b0, 32'h1002, 1'b0);

        // Backpressure: three accepted, fourth held off.
        lsq_ready = 1'b0;
        pops0 = n_pops;
        for (int i = 0; i < 3; i++) begin
            issue(32'h3000 + 32'(i*16), 32'(i), 32'h4, 6'(10+i), 3'b010, 1'b0);
            step();
            chk("bp_acc", last_acc, 1);
        end
        issue(32'h3030, 32'h3, 32'h4, 6'd13, 3'b010, 1'b0);
        step();
        chk("bp_held", last_acc, 0);
        chk("bp_ready", iq_ready, 0);
        chk("bp_head", lsq_addr, 32'h3004);
        lsq_ready = 1'b1;
        #1;
        chk("bp_ready_nocomb", iq_ready, 0);
        step();
        chk("bp_held2", last_acc, 0);
        chk("bp_ready_rise", iq_ready, 1);
        guard = 0;
        while (!last_acc && guard < 10) begin step(); guard++; end
        chk("bp_acc4", last_acc, 1);
        idle();
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin step(); guard++; end
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_count", n_pops - pops0, 4);

        // Flush with FIFO full and S1 valid.
        lsq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(32'h5000 + 32'(i*4), 32'h0, 32'h0, 6'(20+i), 3'b010, 1'b0);
            step();
        end
        idle();
        chk("fl_full", lsq_valid, 1);
        flush = 1'b1;
        #1;
        chk("fl_ready_low", iq_ready, 0);
        step();
        flush = 1'b0;
        #1;
        chk("fl_valid", lsq_valid, 0);
        chk("fl_ready", iq_ready, 1);
        single("post_flush", 32'h6000, 32'h0, 32'h8, 6'd30, 3'b010, 1'b0, 32'h6008, 1'b0);

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            iq_valid        = ($urandom_range(0, 3) != 0);
            iq_op1_data     = $urandom;
            iq_op2_data     = $urandom;
            iq_imm          = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
            iq_rd_tag       = 6'($urandom);
            iq_rd_tag_valid = 1'($urandom);
            iq_funct3       = 3'($urandom);
            iq_ls           = 1'($urandom);
            lsq_ready       = ($urandom_range(0, 2) != 0);
            flush           = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 1'b0; idle(); lsq_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin step(); guard++; end
        chk("rand_drained", exp_q.size(), 0);
        step();
        chk("rand_empty", lsq_valid, 0);

        // Asynchronous reset mid-stream.
        lsq_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            issue(32'h7000 + 32'(i*4), 32'h0, 32'h0, 6'(40+i), 3'b010, 1'b0);
            step();
        end
        idle();
        step();
        chk("mr_pre_valid", lsq_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("mr_valid", lsq_valid, 0);
        chk("mr_addr", lsq_addr, 0);
        exp_q.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("mr_ready", iq_ready, 1);
        single("post_rst", 32'h8000, 32'h0, 32'h4, 6'd50, 3'b010, 1'b0, 32'h8004, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
